// File: rtl/nonzero_index_sequencer.sv
// Sparse-activation front end: accepts a row of neurons and streams only the
// nonzero ones (index + value) to a downstream MAC in ascending index order.
module nonzero_index_sequencer #(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int BYTES_OF_REG    = 36,
  parameter int ITER_BIT_WIDTH  = 6
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    load_valid,
  output logic                                    load_ready,
  input  logic [INPUT_BIT_WIDTH*BYTES_OF_REG-1:0] neuron_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ITER_BIT_WIDTH-1:0]               out_index,
  output logic [INPUT_BIT_WIDTH-1:0]              out_neuron,
  output logic                                    out_last,
  output logic [ITER_BIT_WIDTH-1:0]               nz_count,
  output logic                                    done,
  output logic                                    done_empty
);

  localparam int ROW_W = INPUT_BIT_WIDTH * BYTES_OF_REG;
  localparam logic [BYTES_OF_REG-1:0]    MASK_ZERO = {BYTES_OF_REG{1'b0}};
  localparam logic [BYTES_OF_REG-1:0]    MASK_ONE  = {{(BYTES_OF_REG-1){1'b0}}, 1'b1};
  localparam logic [ITER_BIT_WIDTH-1:0]  IDX_ZERO  = {ITER_BIT_WIDTH{1'b0}};
  localparam logic [INPUT_BIT_WIDTH-1:0] VAL_ZERO  = {INPUT_BIT_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [BYTES_OF_REG-1:0] nonzero_mask(input logic [ROW_W-1:0] row);
    logic [BYTES_OF_REG-1:0] m;
    m = MASK_ZERO;
    for (int k = 0; k < BYTES_OF_REG; k++) begin
      m[k] = |row[k*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH];
    end
    return m;
  endfunction

  function automatic logic [ITER_BIT_WIDTH-1:0] popcount(input logic [BYTES_OF_REG-1:0] m);
    logic [ITER_BIT_WIDTH-1:0] cnt;
    cnt = IDX_ZERO;
    for (int k = 0; k < BYTES_OF_REG; k++) begin
      cnt = cnt + ITER_BIT_WIDTH'(m[k]);
    end
    return cnt;
  endfunction

  // Scanning downward lets the lowest set bit be the last one written.
  function automatic logic [ITER_BIT_WIDTH-1:0] lowest_index(input logic [BYTES_OF_REG-1:0] m);
    logic [ITER_BIT_WIDTH-1:0] idx;
    idx = IDX_ZERO;
    for (int k = BYTES_OF_REG - 1; k >= 0; k--) begin
      idx = m[k] ? ITER_BIT_WIDTH'(k) : idx;
    end
    return idx;
  endfunction

  function automatic logic [INPUT_BIT_WIDTH-1:0] lowest_neuron(input logic [BYTES_OF_REG-1:0] m,
                                                               input logic [ROW_W-1:0]        row);
    logic [INPUT_BIT_WIDTH-1:0] val;
    val = VAL_ZERO;
    for (int k = BYTES_OF_REG - 1; k >= 0; k--) begin
      val = m[k] ? row[k*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH] : val;
    end
    return val;
  endfunction

  function automatic logic single_bit(input logic [BYTES_OF_REG-1:0] m);
    return (m != MASK_ZERO) && ((m & (m - MASK_ONE)) == MASK_ZERO);
  endfunction

  state_e                      state_q, state_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [BYTES_OF_REG-1:0]     mask_q, mask_d;
  logic [BYTES_OF_REG-1:0]     mask_clr;
  logic [BYTES_OF_REG-1:0]     mask_in;
  logic [ITER_BIT_WIDTH-1:0]   nz_q, nz_d;
  logic                        load_ready_q, load_ready_d;
  logic                        out_valid_q, out_valid_d;
  logic [ITER_BIT_WIDTH-1:0]   out_index_q, out_index_d;
  logic [INPUT_BIT_WIDTH-1:0]  out_neuron_q, out_neuron_d;
  logic                        out_last_q, out_last_d;
  logic                        done_q, done_d;
  logic                        done_empty_q, done_empty_d;

  assign mask_in  = nonzero_mask(neuron_in);
  assign mask_clr = mask_q & (mask_q - MASK_ONE);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_q        <= {ROW_W{1'b0}};
      mask_q       <= MASK_ZERO;
      nz_q         <= IDX_ZERO;
      load_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_index_q  <= IDX_ZERO;
      out_neuron_q <= VAL_ZERO;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
      done_empty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      mask_q       <= mask_d;
      nz_q         <= nz_d;
      load_ready_q <= load_ready_d;
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      out_neuron_q <= out_neuron_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
      done_empty_q <= done_empty_d;
    end
  end

  // Next-state: accept a row, retire one mask bit per handshake, pulse done.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    mask_d  = mask_q;
    nz_d    = nz_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          row_d   = neuron_in;
          mask_d  = mask_in;
          nz_d    = popcount(mask_in);
          state_d = (mask_in != MASK_ZERO) ? ST_EMIT : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          mask_d  = mask_clr;
          state_d = (mask_clr == MASK_ZERO) ? ST_DONE : ST_EMIT;
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are precomputed from next state so every port comes from a flop.
  always_comb begin
    load_ready_d = (state_d == ST_IDLE);
    out_valid_d  = (state_d == ST_EMIT);
    out_index_d  = IDX_ZERO;
    out_neuron_d = VAL_ZERO;
    out_last_d   = 1'b0;
    if (state_d == ST_EMIT) begin
      out_index_d  = lowest_index(mask_d);
      out_neuron_d = lowest_neuron(mask_d, row_d);
      out_last_d   = single_bit(mask_d);
    end else begin
      out_index_d  = IDX_ZERO;
      out_neuron_d = VAL_ZERO;
      out_last_d   = 1'b0;
    end
    done_d       = (state_d == ST_DONE);
    done_empty_d = (state_d == ST_DONE) && (nz_d == IDX_ZERO);
  end

  assign load_ready = load_ready_q;
  assign out_valid  = out_valid_q;
  assign out_index  = out_index_q;
  assign out_neuron = out_neuron_q;
  assign out_last   = out_last_q;
  assign nz_count   = nz_q;
  assign done       = done_q;
  assign done_empty = done_empty_q;

endmodule
